// File: rtl/mpmc9_pkg.sv
// Shared types for the mpmc9 response-return path: response payload and FSM state.
package mpmc9_pkg;

  localparam int MPMC9_W = 128;

  typedef struct packed {
    logic               we;
    logic               resv;
    logic [MPMC9_W-1:0] dat;
  } mpmc9_resp_t;

  typedef enum logic {
    RR_IDLE = 1'b0,
    RR_ACK  = 1'b1
  } mpmc9_resp_state_t;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mpmc9_resp_ret_if.sv
// Port bundle between the controller core / client and the response-return stage.
interface mpmc9_resp_ret_if
  import mpmc9_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // Core side: a response transfers on a clock edge where resp_valid_i and
  // resp_ready_o are both high; the core holds the payload stable until then.
  logic          resp_valid_i;
  logic          resp_ready_o;
  logic          resp_we_i;
  logic [W-1:0]  resp_dat_i;
  logic          resp_resv_i;

  // Client side.
  logic          cs_i;
  logic          ack_o;
  logic [W-1:0]  dat_o;
  logic          resv_o;
  logic          we_o;
  logic          drop_o;
  logic [CW-1:0] count_o;
  mpmc9_resp_state_t state_o;

  modport master (
    output resp_valid_i, resp_we_i, resp_dat_i, resp_resv_i, cs_i,
    input  resp_ready_o, ack_o, dat_o, resv_o, we_o, drop_o, count_o, state_o
  );

  modport slave (
    input  resp_valid_i, resp_we_i, resp_dat_i, resp_resv_i, cs_i,
    output resp_ready_o, ack_o, dat_o, resv_o, we_o, drop_o, count_o, state_o
  );

endinterface

// File: rtl/mpmc9_resp_fifo.sv
// Synchronous circular-buffer FIFO; caller guarantees no push when full, no pop when empty.
module mpmc9_resp_fifo
  import mpmc9_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = mpmc9_resp_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  T                             din,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/mpmc9_resp_ret.sv
// Per-port response return: buffers core responses and hands them to the client as
// registered ack pulses, discarding a head entry the client ignores for TMO cycles.
module mpmc9_resp_ret
  import mpmc9_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 4,
  parameter int TMO   = 1023
) (
  input  logic            clk,
  input  logic            rst,
  mpmc9_resp_ret_if.slave bus
);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int TW     = cnt_w(TMO + 1);
  localparam bit TMO_EN = (TMO != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO == 0) ? 0 : TMO - 1);

  typedef struct packed {
    logic         we;
    logic         resv;
    logic [W-1:0] dat;
  } resp_t;

  resp_t         din;
  resp_t         head;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          tmo_hit;

  mpmc9_resp_state_t state_q;
  logic              ack_q;
  logic              drop_q;
  logic              we_q;
  logic              resv_q;
  logic [W-1:0]      dat_q;
  logic [TW-1:0]     tmo_q;

  assign din     = '{we: bus.resp_we_i, resv: bus.resp_resv_i, dat: bus.resp_dat_i};
  assign push    = bus.resp_valid_i & ~fifo_full;
  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);
  // A client ack takes priority over the timeout when both land on the same edge.
  assign pop     = (state_q == RR_IDLE) & ~fifo_empty & (bus.cs_i | tmo_hit);

  mpmc9_resp_fifo #(
    .DEPTH (DEPTH),
    .T     (resp_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RR_IDLE;
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      resv_q  <= 1'b0;
      dat_q   <= '0;
      tmo_q   <= '0;
    end else begin
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        RR_IDLE: begin
          if (fifo_empty) begin
            tmo_q <= '0;
          end else if (bus.cs_i) begin
            state_q <= RR_ACK;
            ack_q   <= 1'b1;
            we_q    <= head.we;
            resv_q  <= head.resv;
            dat_q   <= head.dat;
            tmo_q   <= '0;
          end else if (tmo_hit) begin
            drop_q <= 1'b1;
            tmo_q  <= '0;
          end else if (TMO_EN) begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        // The enforced idle cycle lets the client release cs_i between acks.
        RR_ACK:  state_q <= RR_IDLE;
        default: state_q <= RR_IDLE;
      endcase
    end
  end

  assign bus.resp_ready_o = ~fifo_full;
  assign bus.ack_o        = ack_q;
  assign bus.drop_o       = drop_q;
  assign bus.we_o         = we_q;
  assign bus.resv_o       = resv_q;
  assign bus.dat_o        = dat_q;
  assign bus.count_o      = fifo_count;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_mpmc9_resp_ret.sv
// Bench for mpmc9_resp_ret: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based model of the stage.
module tb_mpmc9_resp_ret;
  import mpmc9_pkg::*;

  localparam int W     = 128;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mpmc9_resp_ret_if #(.W(W), .DEPTH(DEPTH)) bus ();

  mpmc9_resp_ret #(.W(W), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(bit v, bit we, bit resv, logic [W-1:0] d, bit cs);
    bus.resp_valid_i = v;
    bus.resp_we_i    = we;
    bus.resp_resv_i  = resv;
    bus.resp_dat_i   = d;
    bus.cs_i         = cs;
  endtask

  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    logic         we;
    logic         resv;
    logic [W-1:0] dat;
  } ent_t;

  ent_t         mq[$];
  bit           m_live = 0;
  bit           m_ack  = 0;
  bit           m_drop = 0;
  bit           m_we   = 0;
  bit           m_resv = 0;
  bit           m_hold = 0;
  logic [W-1:0] m_dat  = '0;
  int           m_wait = 0;

  always @(posedge clk) begin
    bit   pushed;
    ent_t e;
    ent_t h;
    if (rst) begin
      mq.delete();
      m_live = 1; m_ack = 0; m_drop = 0; m_we = 0; m_resv = 0;
      m_dat = '0; m_hold = 0; m_wait = 0;
    end else if (m_live) begin
      pushed = bus.resp_valid_i && (mq.size() < DEPTH);
      e = '{bus.resp_we_i, bus.resp_resv_i, bus.resp_dat_i};
      m_ack  = 0;
      m_drop = 0;
      if (m_hold) begin
        m_hold = 0;
      end else if (mq.size() == 0) begin
        m_wait = 0;
      end else if (bus.cs_i) begin
        h = mq.pop_front();
        m_we = h.we; m_resv = h.resv; m_dat = h.dat;
        m_ack = 1; m_hold = 1; m_wait = 0;
      end else if (m_wait + 1 == TMO) begin
        void'(mq.pop_front());
        m_drop = 1; m_wait = 0;
      end else begin
        m_wait++;
      end
      if (pushed) mq.push_back(e);
    end
    #1;
    if (m_live) begin
      chk("m_ack",   bus.ack_o,  m_ack);
      chk("m_drop",  bus.drop_o, m_drop);
      chk("m_count", bus.count_o, mq.size());
      chk("m_ready", bus.resp_ready_o, mq.size() != DEPTH);
      chk("m_dat",   bus.dat_o,  m_dat);
      chk("m_we",    bus.we_o,   m_we);
      chk("m_resv",  bus.resv_o, m_resv);
      chk("m_state", bus.state_o, m_ack ? RR_ACK : RR_IDLE);
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int got[$];
    int cyc_at[$];
    bit cs_lvl;
    drive(0, 0, 0, '0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    at_edge();
    chk("rst_count", bus.count_o, 0);
    chk("rst_ack",   bus.ack_o,   0);
    chk("rst_dat",   bus.dat_o,   0);
    chk("rst_ready", bus.resp_ready_o, 1);

    // Single read, minimum latency.
    @(negedge clk); drive(1, 0, 0, 128'hDEAD_BEEF, 1);
    at_edge();
    chk("s1_no_ack_at_push", bus.ack_o, 0);
    chk("s1_count_pushed",   bus.count_o, 1);
    @(negedge clk); drive(0, 0, 0, '0, 1);
    at_edge();
    chk("s1_ack",   bus.ack_o, 1);
    chk("s1_dat",   bus.dat_o, 128'hDEAD_BEEF);
    chk("s1_we",    bus.we_o,  0);
    chk("s1_count", bus.count_o, 0);
    @(negedge clk); drive(0, 0, 0, '0, 0);
    at_edge();
    chk("s1_ack_done", bus.ack_o, 0);

    // Fill, back-pressure, then drain in order on alternate cycles.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); drive(1, 0, 0, W'(i), 0);
      at_edge();
    end
    chk("s2_ready_full", bus.resp_ready_o, 0);
    chk("s2_count_full", bus.count_o, 4);
    @(negedge clk); drive(1, 0, 0, W'(5), 0);
    at_edge();
    at_edge();
    chk("s2_held_off", bus.count_o, 4);
    @(negedge clk); drive(0, 0, 0, '0, 1);
    for (int c = 0; c < 12; c++) begin
      at_edge();
      if (c == 0) chk("s2_ready_after_pop", bus.resp_ready_o, 1);
      if (bus.ack_o === 1'b1) begin
        got.push_back(int'(bus.dat_o[31:0]));
        cyc_at.push_back(c);
      end
    end
    chk("s2_ack_total", got.size(), 4);
    for (int k = 0; k < got.size(); k++) begin
      chk("s2_order", got[k], k + 1);
      if (k > 0) chk("s2_spacing", cyc_at[k] - cyc_at[k-1], 2);
    end
    @(negedge clk); drive(0, 0, 0, '0, 0);

    // Simultaneous push and pop at count=1.
    @(negedge clk); drive(1, 0, 0, 'h11, 0);
    at_edge();
    @(negedge clk); drive(1, 0, 0, 'h22, 1);
    at_edge();
    chk("s3_ack_old",   bus.ack_o, 1);
    chk("s3_dat_old",   bus.dat_o, 'h11);
    chk("s3_count_one", bus.count_o, 1);
    @(negedge clk); drive(0, 0, 0, '0, 1);
    at_edge();
    chk("s3_gap", bus.ack_o, 0);
    at_edge();
    chk("s3_ack_new",   bus.ack_o, 1);
    chk("s3_dat_new",   bus.dat_o, 'h22);
    chk("s3_count_end", bus.count_o, 0);
    @(negedge clk); drive(0, 0, 0, '0, 0);

    // Timeout drop, then ack winning on the deadline cycle.
    @(negedge clk); drive(1, 0, 0, 'h33, 0);
    at_edge();
    @(negedge clk); drive(0, 0, 0, '0, 0);
    for (int i = 1; i <= TMO; i++) begin
      at_edge();
      chk("s4_drop_timing", bus.drop_o, i == TMO);
      chk("s4_no_ack",      bus.ack_o, 0);
    end
    chk("s4_count_dropped", bus.count_o, 0);
    at_edge();
    chk("s4_drop_pulse", bus.drop_o, 0);
    @(negedge clk); drive(1, 0, 0, 'h44, 0);
    at_edge();
    @(negedge clk); drive(0, 0, 0, '0, 0);
    for (int i = 1; i < TMO; i++) begin
      at_edge();
      chk("s4b_no_drop_early", bus.drop_o, 0);
    end
    @(negedge clk); drive(0, 0, 0, '0, 1);
    at_edge();
    chk("s4b_ack_wins", bus.ack_o, 1);
    chk("s4b_no_drop",  bus.drop_o, 0);
    chk("s4b_dat",      bus.dat_o, 'h44);
    @(negedge clk); drive(0, 0, 0, '0, 0);

    // Store-conditional completion.
    @(negedge clk); drive(1, 1, 1, 'h55, 1);
    at_edge();
    @(negedge clk); drive(0, 0, 0, '0, 1);
    at_edge();
    chk("s5_ack",  bus.ack_o, 1);
    chk("s5_we",   bus.we_o, 1);
    chk("s5_resv", bus.resv_o, 1);
    @(negedge clk); drive(0, 0, 0, '0, 0);

    // Reset with entries pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1, 0, 0, W'(32'h60 + i), 0);
      at_edge();
    end
    chk("s6_pending", bus.count_o, 3);
    @(negedge clk); drive(0, 0, 0, '0, 0); rst = 1'b1;
    at_edge();
    chk("s6_count", bus.count_o, 0);
    chk("s6_ack",   bus.ack_o, 0);
    chk("s6_ready", bus.resp_ready_o, 1);
    @(negedge clk); rst = 1'b0; drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 6; i++) begin
      at_edge();
      chk("s6_no_stale_ack", bus.ack_o, 0);
    end

    // Randomized traffic; cs_i held in runs so timeouts occur.
    cs_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) cs_lvl = ~cs_lvl;
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom, $urandom, $urandom}, cs_lvl);
    end
    @(negedge clk); rst = 1'b0; drive(0, 0, 0, '0, 0);
    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpmc9_resp_ret.md
Name: mpmc9_resp_ret

Overview:
- Per-port response-return stage of the mpmc9 multi-port memory controller; runs opposite to the per-port request sync register.
- Accepts read-data and write-completion responses from the controller core through a valid/ready handshake and buffers them in a small FIFO.
- Returns them to the client as registered one-cycle ack pulses, with data and a reservation-status bit.
- Responses left waiting on an idle client are dropped after a timeout so the port never deadlocks.

Parameters:
- W, 128, data width in bits.
- DEPTH, 4, response FIFO entries; power of two, 2..16.
- TMO, 1023, cycles a head entry may wait with cs_i low before it is discarded; 0 disables the timeout.

Ports:
- clk  input  1  controller clock.
- rst  input  1  synchronous, active-high reset.
- resp_valid_i  input  1  core presents a response.
- resp_ready_o  output  1  stage can accept a response.
- resp_we_i  input  1  response is a write completion (1) or read data (0).
- resp_dat_i  input  W  read data; don't-care for writes.
- resp_resv_i  input  1  reservation result: 1 = store-conditional succeeded or reservation set.
- cs_i  input  1  client cycle active (registered client select).
- ack_o  output  1  one-cycle response pulse to the client.
- dat_o  output  W  response data; valid while ack_o=1, holds its value otherwise.
- resv_o  output  1  reservation result; qualified by ack_o.
- we_o  output  1  type of the acked response.
- drop_o  output  1  one-cycle pulse when a head entry is discarded on timeout.
- count_o  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - FIFO is emptied and count_o=0.
  - ack_o=0, drop_o=0, we_o=0, resv_o=0, dat_o=0.
  - FSM returns to IDLE and the timeout counter is cleared.
  - A reset mid-operation discards all pending entries; no ack is issued for them.
- Input handshake:
  - resp_ready_o = (count != DEPTH), decoded from the registered count only. It is low when full even if a pop happens in the same cycle.
  - An entry is pushed at an edge where resp_valid_i & resp_ready_o.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Push and pop at the same edge leave the count unchanged and are legal at any occupancy, including count=1.
- FSM states: IDLE, ACK.
  - IDLE -> ACK when count!=0 & cs_i. At that edge the head is popped and dat_o/we_o/resv_o are loaded from it; ack_o=1 next cycle.
  - ACK -> IDLE unconditionally; ack_o=0 next cycle.
  - This guarantees at least one idle cycle between acks, so the client can drop cs_i.
  - Back-to-back pending entries with cs_i held high produce ack pulses every second cycle.
- Latency: a response pushed at edge E gives ack_o=1 from edge E+1 at the earliest (empty FIFO, cs_i=1, FSM in IDLE).
- Ordering: responses are returned strictly in arrival order.
- Timeout:
  - The counter increments each cycle in IDLE with count!=0 and cs_i=0.
  - It clears on cs_i=1, on any pop, or when count=0.
  - When it reaches TMO, the head is popped without ack, drop_o pulses for one cycle, and the counter clears.
  - If cs_i rises in the same cycle the counter reaches TMO, the ack wins and no drop occurs.
- Outputs are registered; no combinational path from cs_i or resp_* to ack_o/dat_o. resp_ready_o is purely registered-count decode.

Decomposition:
- mpmc9_pkg gains a typedef mpmc9_resp_t, a packed struct {we, resv, dat[W-1:0]}, plus the FSM state enum mpmc9_resp_state_t {RR_IDLE, RR_ACK}.
- Sub-module mpmc9_resp_fifo: a parameterised synchronous FIFO (push, pop, din, dout, count, full, empty) holding mpmc9_resp_t.
- The FSM and timeout logic stay in mpmc9_resp_ret.

Test Plan:
- Reset, then one read response dat=128'hDEAD_BEEF, resv=0, with cs_i=1 -> ack_o=1 exactly one cycle after the push edge, dat_o=128'hDEAD_BEEF, we_o=0; count_o returns to 0.
- Push 4 responses (dat=1..4) with cs_i=0 -> resp_ready_o=0 after the 4th; a 5th valid is held off. Raise cs_i -> acks with dat 1,2,3,4 on alternate cycles; resp_ready_o=1 after the first pop.
- FIFO at count=1 with a simultaneous push and ack pop -> count_o stays 1; next ack carries the newer data.
- TMO=8, one entry pending, cs_i=0 -> drop_o pulses 8 cycles after the entry becomes head, count_o=0, no ack_o. A repeat with cs_i rising on the 8th cycle -> ack, no drop.
- Store-conditional completion we=1, resv=1 -> ack_o with we_o=1, resv_o=1.
- Three entries pending, rst asserted for one cycle -> count_o=0, ack_o=0, resp_ready_o=1 on the next cycle; no stale ack follows.
